// File: rtl/gpu_timing_pkg.sv
// rtl/gpu_timing_pkg.sv - 640x480@60 timing constants, axis phase encoding and total helper
package gpu_timing_pkg;

  localparam int H_ACTIVE_640 = 640;
  localparam int H_FP_640     = 16;
  localparam int H_SYNC_640   = 96;
  localparam int H_BP_640     = 48;
  localparam int V_ACTIVE_480 = 480;
  localparam int V_FP_480     = 10;
  localparam int V_SYNC_480   = 2;
  localparam int V_BP_480     = 33;

  // Counters are 10 bits wide, so neither axis may exceed 1024 positions.
  localparam int AXIS_MAX_TOTAL = 1024;

  typedef enum logic [1:0] {
    PH_ACT  = 2'd0,
    PH_FP   = 2'd1,
    PH_SYNC = 2'd2,
    PH_BP   = 2'd3
  } phase_t;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one timing axis: wrapping counter, ACT/FP/SYNC/BP phase and sync level
module vga_axis_counter
  import gpu_timing_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_640,
  parameter int FP     = H_FP_640,
  parameter int SYNC   = H_SYNC_640,
  parameter int BP     = H_BP_640,
  parameter bit POL    = 1'b0
) (
  input  logic       vgaClk,
  input  logic       rst,
  input  logic       i_advance,
  output logic [9:0] o_count,
  output logic [1:0] o_phase,
  output logic [1:0] o_phase_next,
  output logic       o_sync,
  output logic       o_wrap
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [9:0] LAST       = 10'(TOTAL - 1);
  localparam logic [9:0] FP_START   = 10'(ACTIVE);
  localparam logic [9:0] SYNC_START = 10'(ACTIVE + FP);
  localparam logic [9:0] BP_START   = 10'(ACTIVE + FP + SYNC);

  if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_phase_len
    $error("vga_axis_counter: every phase length must be at least 1");
  end
  if (TOTAL > AXIS_MAX_TOTAL) begin : g_bad_total
    $error("vga_axis_counter: axis total %0d exceeds %0d", TOTAL, AXIS_MAX_TOTAL);
  end

  logic [9:0] r_count;
  phase_t     r_phase;
  logic       r_sync;
  logic       w_last;
  logic [9:0] w_next_count;
  phase_t     w_phase_next;

  assign w_last = (r_count == LAST);

  always_comb begin
    w_next_count = r_count;
    w_phase_next = r_phase;
    if (i_advance) begin
      w_next_count = w_last ? 10'd0 : r_count + 10'd1;
      case (r_phase)
        PH_ACT:  if (w_next_count == FP_START)   w_phase_next = PH_FP;
        PH_FP:   if (w_next_count == SYNC_START) w_phase_next = PH_SYNC;
        PH_SYNC: if (w_next_count == BP_START)   w_phase_next = PH_BP;
        PH_BP:   if (w_last)                     w_phase_next = PH_ACT;
        default:                                 w_phase_next = PH_BP;
      endcase
    end
  end

  // Reset parks the axis on its last position so the first free edge lands on 0.
  always_ff @(posedge vgaClk) begin
    if (rst) begin
      r_count <= LAST;
      r_phase <= PH_BP;
      r_sync  <= !POL;
    end else begin
      r_count <= w_next_count;
      r_phase <= w_phase_next;
      r_sync  <= (w_phase_next == PH_SYNC) ? POL : !POL;
    end
  end

  assign o_count      = r_count;
  assign o_phase      = r_phase;
  assign o_phase_next = w_phase_next;
  assign o_sync       = r_sync;
  assign o_wrap       = w_last;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - programmable VGA timing generator with registered strobes and frame counter
module vga_timing_gen
  import gpu_timing_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_640,
  parameter int H_FP       = H_FP_640,
  parameter int H_SYNC     = H_SYNC_640,
  parameter int H_BP       = H_BP_640,
  parameter int V_ACTIVE   = V_ACTIVE_480,
  parameter int V_FP       = V_FP_480,
  parameter int V_SYNC     = V_SYNC_480,
  parameter int V_BP       = V_BP_480,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0
) (
  input  logic       vgaClk,
  input  logic       rst,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       h_sync,
  output logic       v_sync,
  output logic       blanking_start,
  output logic       frame_start,
  output logic       line_start,
  output logic [7:0] frame_count
);

  logic [9:0] w_h_count;
  logic [1:0] w_h_phase;
  logic [1:0] w_h_phase_next;
  logic       w_h_sync;
  logic       w_h_wrap;
  logic [9:0] w_v_count;
  logic [1:0] w_v_phase;
  logic [1:0] w_v_phase_next;
  logic       w_v_sync;
  logic       w_v_wrap;
  logic       w_line_next;
  logic       w_frame_next;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_SYNC_POL)
  ) u_h_axis (
    .vgaClk      (vgaClk),
    .rst         (rst),
    .i_advance   (1'b1),
    .o_count     (w_h_count),
    .o_phase     (w_h_phase),
    .o_phase_next(w_h_phase_next),
    .o_sync      (w_h_sync),
    .o_wrap      (w_h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_SYNC_POL)
  ) u_v_axis (
    .vgaClk      (vgaClk),
    .rst         (rst),
    .i_advance   (w_h_wrap),
    .o_count     (w_v_count),
    .o_phase     (w_v_phase),
    .o_phase_next(w_v_phase_next),
    .o_sync      (w_v_sync),
    .o_wrap      (w_v_wrap)
  );

  // Strobes are computed from the position the counters move to, so they line up with x/y.
  assign w_line_next  = (w_h_phase == PH_BP) && (w_h_phase_next == PH_ACT);
  assign w_frame_next = w_line_next && w_v_wrap;

  logic       r_active;
  logic       r_blanking_start;
  logic       r_frame_start;
  logic       r_line_start;
  logic [7:0] r_frame_count;
  logic       r_first_frame;

  always_ff @(posedge vgaClk) begin
    if (rst) begin
      r_active         <= 1'b0;
      r_blanking_start <= 1'b0;
      r_frame_start    <= 1'b0;
      r_line_start     <= 1'b0;
      r_frame_count    <= 8'd0;
      r_first_frame    <= 1'b1;
    end else begin
      r_active         <= (w_h_phase_next == PH_ACT) && (w_v_phase_next == PH_ACT);
      r_blanking_start <= (w_v_phase == PH_ACT) && (w_v_phase_next == PH_FP);
      r_frame_start    <= w_frame_next;
      r_line_start     <= w_line_next;
      r_first_frame    <= 1'b0;
      // The frame entered straight out of reset is frame 0, not an increment.
      if (w_frame_next && !r_first_frame) begin
        r_frame_count <= r_frame_count + 8'd1;
      end
    end
  end

  assign x              = w_h_count;
  assign y              = w_v_count;
  assign active         = r_active;
  assign h_sync         = w_h_sync;
  assign v_sync         = w_v_sync;
  assign blanking_start = r_blanking_start;
  assign frame_start    = r_frame_start;
  assign line_start     = r_line_start;
  assign frame_count    = r_frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized-reset bench for vga_timing_gen against a positional timing model
module tb_vga_timing_gen;

  typedef struct {
    int x; int y;
    bit act; bit hs; bit vs; bit bs; bit fs; bit ls;
    int fc;
  } exp_t;

  logic clk;
  logic rst_a, rst_b;
  int   checks = 0;
  int   errors = 0;

  logic [9:0] a_x, a_y, b_x, b_y;
  logic a_active, a_hs, a_vs, a_bs, a_fs, a_ls;
  logic b_active, b_hs, b_vs, b_bs, b_fs, b_ls;
  logic [7:0] a_fc, b_fc;

  vga_timing_gen u_a (
    .vgaClk(clk), .rst(rst_a), .x(a_x), .y(a_y), .active(a_active),
    .h_sync(a_hs), .v_sync(a_vs), .blanking_start(a_bs), .frame_start(a_fs),
    .line_start(a_ls), .frame_count(a_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
  ) u_b (
    .vgaClk(clk), .rst(rst_b), .x(b_x), .y(b_y), .active(b_active),
    .h_sync(b_hs), .v_sync(b_vs), .blanking_start(b_bs), .frame_start(b_fs),
    .line_start(b_ls), .frame_count(b_fc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Output state is a pure function of cycles elapsed since reset release (-1 = held in reset).
  function automatic exp_t model(input int t, input int ha, input int hf, input int hsw, input int hb,
                                 input int va, input int vf, input int vsw, input int vb,
                                 input bit hp, input bit vp);
    exp_t e;
    int ht, vt, line;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    if (t < 0) begin
      e.x = ht - 1; e.y = vt - 1; e.act = 0; e.hs = !hp; e.vs = !vp;
      e.bs = 0; e.fs = 0; e.ls = 0; e.fc = 0;
    end else begin
      e.x  = t % ht;
      line = t / ht;
      e.y  = line % vt;
      e.fc = (line / vt) % 256;
      e.act = (e.x < ha) && (e.y < va);
      e.hs = (e.x >= ha + hf && e.x < ha + hf + hsw) ? hp : !hp;
      e.vs = (e.y >= va + vf && e.y < va + vf + vsw) ? vp : !vp;
      e.bs = (e.x == 0) && (e.y == va);
      e.fs = (e.x == 0) && (e.y == 0);
      e.ls = (e.x == 0);
    end
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input string n, input exp_t e, input int x, input int y, input bit act,
                     input bit hs, input bit vs, input bit bs, input bit fs, input bit ls, input int fc);
    chk({n, ".x"}, x, e.x);
    chk({n, ".y"}, y, e.y);
    chk({n, ".active"}, int'(act), int'(e.act));
    chk({n, ".h_sync"}, int'(hs), int'(e.hs));
    chk({n, ".v_sync"}, int'(vs), int'(e.vs));
    chk({n, ".blanking_start"}, int'(bs), int'(e.bs));
    chk({n, ".frame_start"}, int'(fs), int'(e.fs));
    chk({n, ".line_start"}, int'(ls), int'(e.ls));
    chk({n, ".frame_count"}, fc, e.fc);
  endtask

  int ta = -1;
  int tb = -1;
  always @(posedge clk) begin
    ta <= rst_a ? -1 : ta + 1;
    tb <= rst_b ? -1 : tb + 1;
  end

  always @(negedge clk) begin
    exp_t ea, eb;
    ea = model(ta, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
    eb = model(tb, 8, 1, 2, 1, 6, 1, 1, 1, 1'b1, 1'b1);
    cmp("A", ea, int'(a_x), int'(a_y), a_active, a_hs, a_vs, a_bs, a_fs, a_ls, int'(a_fc));
    cmp("B", eb, int'(b_x), int'(b_y), b_active, b_hs, b_vs, b_bs, b_fs, b_ls, int'(b_fc));
  end

  int b_fs_cnt = 0;
  int fc_at2 = -1, fc_at3 = -1, fc_at257 = -1;
  int cyc = 0;
  int last_fs_cyc = 0;
  int b_period = -1;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (b_fs === 1'b1) begin
      b_fs_cnt <= b_fs_cnt + 1;
      if (b_fs_cnt == 1) fc_at2 <= int'(b_fc);
      if (b_fs_cnt == 2) fc_at3 <= int'(b_fc);
      if (b_fs_cnt == 256) fc_at257 <= int'(b_fc);
      if (b_fs_cnt >= 1) b_period <= cyc - last_fs_cyc;
      last_fs_cyc <= cyc;
    end
  end

  initial begin
    int act_n, hs_n, first_hs, ls_n, n;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_x", int'(a_x), 799);
    chk("rst_y", int'(a_y), 524);
    chk("rst_active", int'(a_active), 0);
    chk("rst_h_sync", int'(a_hs), 1);
    chk("rst_v_sync", int'(a_vs), 1);
    chk("rst_frame_count", int'(a_fc), 0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    chk("rel_x", int'(a_x), 0);
    chk("rel_y", int'(a_y), 0);
    chk("rel_active", int'(a_active), 1);
    chk("rel_frame_start", int'(a_fs), 1);
    chk("rel_line_start", int'(a_ls), 1);

    act_n = 0; hs_n = 0; first_hs = -1; ls_n = 0;
    for (int i = 0; i < 800; i++) begin
      if (a_active) act_n++;
      if (!a_hs) begin
        if (first_hs < 0) first_hs = int'(a_x);
        hs_n++;
      end
      if (a_ls) ls_n++;
      @(negedge clk);
    end
    chk("line_active_width", act_n, 640);
    chk("line_hsync_width", hs_n, 96);
    chk("line_hsync_start", first_hs, 656);
    chk("line_start_per_line", ls_n, 1);
    chk("line2_line_start", int'(a_ls), 1);
    chk("line2_y", int'(a_y), 1);

    n = 0;
    while (b_fs_cnt < 257 && n < 40000) begin
      @(negedge clk);
      n++;
    end
    chk("b_257_frames_timeout", int'(b_fs_cnt >= 257), 1);
    @(negedge clk);
    chk("b_fc_at_2nd", fc_at2, 1);
    chk("b_fc_at_3rd", fc_at3, 2);
    chk("b_fc_at_257th", fc_at257, 0);
    chk("b_frame_period", b_period, 108);

    n = 0;
    while (b_bs !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("b_blank_x", int'(b_x), 0);
    chk("b_blank_y", int'(b_y), 6);
    chk("b_blank_active", int'(b_active), 0);

    n = 0;
    while (!(b_x == 10'd9 && b_y == 10'd7) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("mid_h_sync_in_window", int'(b_hs), 1);
    chk("mid_v_sync_in_window", int'(b_vs), 1);
    rst_b = 1'b1;
    @(negedge clk);
    chk("mid_rst_x", int'(b_x), 11);
    chk("mid_rst_y", int'(b_y), 8);
    chk("mid_rst_h_sync", int'(b_hs), 0);
    chk("mid_rst_v_sync", int'(b_vs), 0);
    @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    chk("mid_rel_x", int'(b_x), 0);
    chk("mid_rel_y", int'(b_y), 0);
    chk("mid_rel_frame_start", int'(b_fs), 1);
    chk("mid_rel_frame_count", int'(b_fc), 0);

    repeat (3000) begin
      rst_a = ($urandom_range(0, 199) == 0);
      rst_b = ($urandom_range(0, 49) == 0);
      @(negedge clk);
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
